// File: rtl/rx_dphy_lane_if.sv
// Lane-side signal bundle for rx_dphy_lane.
// The slave modport is the lane controller.
// The master modport is the analog front end plus the protocol layer facing it.
interface rx_dphy_lane_if;
   logic       LP_Dp;
   logic       LP_Dn;
   logic [7:0] HS_DataIn;
   logic       HSRX_EN;
   logic       RxActiveHS;
   logic       RxSyncHS;
   logic       RxValidHS;
   logic [7:0] RxDataHS;
   logic       ErrSotHS;
   logic       ErrSotSyncHS;
   logic       RxStopState;
   logic [2:0] DphyRxState;

   modport master (
      output LP_Dp, LP_Dn, HS_DataIn,
      input  HSRX_EN, RxActiveHS, RxSyncHS, RxValidHS, RxDataHS,
      input  ErrSotHS, ErrSotSyncHS, RxStopState, DphyRxState
   );

   modport slave (
      input  LP_Dp, LP_Dn, HS_DataIn,
      output HSRX_EN, RxActiveHS, RxSyncHS, RxValidHS, RxDataHS,
      output ErrSotHS, ErrSotSyncHS, RxStopState, DphyRxState
   );
endinterface

// File: rtl/rx_dphy_lane.sv
// MIPI D-PHY receive data-lane controller.
// It decodes LP line states to detect SoT and enables the HS receiver after the settle window.
// It then locks onto the HS sync byte at any bit offset and streams aligned payload until LP-11.
// Optional: define RX_SOT_1BIT_TOL_EN to accept a sync byte with a single bit error.
// A byte accepted that way is flagged on ErrSotHS.
module rx_dphy_lane #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned SYNC_TIMEOUT  = 16,
   parameter logic [7:0]  SYNC_WORD     = 8'hB8
) (
   input logic           RxByteClk,
   input logic           RxRst,
   rx_dphy_lane_if.slave lane
);

   typedef enum logic [2:0] {
      RxStop   = 3'd0,
      RxHsRqst = 3'd1,
      RxHsPrep = 3'd2,
      RxHsSync = 3'd3,
      RxHsData = 3'd4,
      RxErr    = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  prev_q, prev_d;
   logic [2:0]  k_q, k_d;
   logic        hsrx_en_q, hsrx_en_d;
   logic        active_q, active_d;
   logic        sync_q, sync_d;
   logic        valid_q, valid_d;
   logic [7:0]  data_q, data_d;
   logic        err_sot_q, err_sot_d;
   logic        err_sync_q, err_sync_d;
   logic        stop_q, stop_d;

   logic [1:0]  lp;
   logic [15:0] win;
   logic        exact_hit, match_hit, match_err, lock;
   logic [2:0]  exact_k, match_k;

   assign lp  = {lane.LP_Dp, lane.LP_Dn};
   assign win = {lane.HS_DataIn, prev_q};

   // Sync search over all eight bit offsets; descending scan leaves the lowest hit.
   always_comb begin
      exact_hit = 1'b0;
      exact_k   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (win[i +: 8] == SYNC_WORD) begin
            exact_hit = 1'b1;
            exact_k   = 3'(i);
         end
      end
   end

`ifdef RX_SOT_1BIT_TOL_EN
   logic       near_hit;
   logic [2:0] near_k;

   // Single-bit-error fallback, used only when no offset matches exactly.
   always_comb begin
      near_hit = 1'b0;
      near_k   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if ($countones(win[i +: 8] ^ SYNC_WORD) == 1) begin
            near_hit = 1'b1;
            near_k   = 3'(i);
         end
      end
   end

   assign match_hit = exact_hit | near_hit;
   assign match_k   = exact_hit ? exact_k : near_k;
   assign match_err = ~exact_hit & near_hit;
`else
   assign match_hit = exact_hit;
   assign match_k   = exact_k;
   assign match_err = 1'b0;
`endif

   // Next state, counters and registered outputs; outputs track the state being entered.
   always_comb begin
      state_d = state_q;
      if (state_q != RxStop && lp == 2'b11) begin
         state_d = RxStop;
      end else begin
         unique case (state_q)
            RxStop:   if (lp == 2'b01) state_d = RxHsRqst;
            RxHsRqst: begin
               if (lp == 2'b00)      state_d = RxHsPrep;
               else if (lp == 2'b10) state_d = RxStop;
            end
            RxHsPrep: if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_d = RxHsSync;
            RxHsSync: begin
               if (match_hit)                             state_d = RxHsData;
               else if (cnt_q == 8'(SYNC_TIMEOUT - 1))    state_d = RxErr;
            end
            RxHsData: state_d = RxHsData;
            RxErr:    state_d = RxErr;
            default:  state_d = RxStop;
         endcase
      end

      // Only the settle and search phases need a counter; it restarts on every state entry.
      if (state_d != state_q || !(state_q inside {RxHsPrep, RxHsSync})) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      lock       = (state_q == RxHsSync) && (state_d == RxHsData);
      prev_d     = lane.HS_DataIn;
      k_d        = lock ? match_k : k_q;
      hsrx_en_d  = state_d inside {RxHsPrep, RxHsSync, RxHsData};
      active_d   = (state_d == RxHsData);
      sync_d     = lock;
      err_sot_d  = lock & match_err;
      err_sync_d = (state_q == RxHsSync) && (state_d == RxErr);
      // The byte sampled while LP-11 arrives is dropped: the burst ends on that edge.
      valid_d    = (state_q == RxHsData) && (state_d == RxHsData);
      data_d     = valid_d ? win[k_q +: 8] : data_q;
      stop_d     = (state_q == RxStop);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge RxByteClk) begin
      if (RxRst) begin
         state_q    <= RxStop;
         cnt_q      <= 8'd0;
         prev_q     <= 8'd0;
         k_q        <= 3'd0;
         hsrx_en_q  <= 1'b0;
         active_q   <= 1'b0;
         sync_q     <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= 8'd0;
         err_sot_q  <= 1'b0;
         err_sync_q <= 1'b0;
         stop_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_q     <= prev_d;
         k_q        <= k_d;
         hsrx_en_q  <= hsrx_en_d;
         active_q   <= active_d;
         sync_q     <= sync_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         err_sot_q  <= err_sot_d;
         err_sync_q <= err_sync_d;
         stop_q     <= stop_d;
      end
   end

   assign lane.HSRX_EN      = hsrx_en_q;
   assign lane.RxActiveHS   = active_q;
   assign lane.RxSyncHS     = sync_q;
   assign lane.RxValidHS    = valid_q;
   assign lane.RxDataHS     = data_q;
   assign lane.ErrSotHS     = err_sot_q;
   assign lane.ErrSotSyncHS = err_sync_q;
   assign lane.RxStopState  = stop_q;
   assign lane.DphyRxState  = state_q;

endmodule

// File: doc/rx_dphy_lane.md
# rx_dphy_lane

Receive-side lane controller for the MIPI D-PHY data lane, counterpart to the lane transmitter. It decodes the low-power line states to detect Start-of-Transmission and enables the HS receiver after the settle window. It then finds the HS sync byte at any bit offset in the unaligned deserialized stream and delivers byte-aligned payload until the line returns to LP-11. It sits between the analog LP/HS receivers plus 1:8 deserializer and the protocol layer.

## Interface
- SETTLE_CYCLES, 4: RxByteClk cycles HSRX_EN is held before sync search starts (THS-SETTLE); valid range 1..15.
- SYNC_TIMEOUT, 16: maximum cycles spent in sync search before ErrSotSyncHS; valid range 2..255.
- SYNC_WORD, 8'hB8: HS leader sync byte.
- RxByteClk  in  1  sole clock; byte clock from the clock lane.
- RxRst  in  1  synchronous, active-high reset.
- LP_Dp, LP_Dn  in  1 each  LP receiver outputs, already synchronized to RxByteClk.
- HS_DataIn  in  8  unaligned deserialized HS bits; bit 0 received earliest.
- HSRX_EN  out  1  enables HS receiver and termination.
- RxActiveHS  out  1  HS burst locked and in progress.
- RxSyncHS  out  1  one-cycle pulse on sync lock.
- RxValidHS  out  1  RxDataHS carries a payload byte.
- RxDataHS  out  8  aligned payload byte.
- ErrSotHS  out  1  one-cycle pulse: sync accepted with a 1-bit error.
- ErrSotSyncHS  out  1  one-cycle pulse: sync search timed out.
- RxStopState  out  1  lane in LP-11 Stop state.
- DphyRxState  out  3  current FSM state encoding.

## Operation
- Line state is {LP_Dp, LP_Dn}. Encoding: RX_STOP=0, RX_HS_RQST=1, RX_HS_PREP=2, RX_HS_SYNC=3, RX_HS_DATA=4, RX_ERR=5.
- RX_STOP:
  - LP-01 -> RX_HS_RQST.
  - Anything else: stay.
- RX_HS_RQST:
  - LP-00 -> RX_HS_PREP.
  - LP-01: stay.
  - LP-11 or LP-10 -> RX_STOP.
- RX_HS_PREP:
  - HSRX_EN=1; settle counter runs 0..SETTLE_CYCLES-1, then -> RX_HS_SYNC.
  - LP-11 -> RX_STOP.
- RX_HS_SYNC:
  - HSRX_EN=1; timeout counter runs.
  - Window W = {HS_DataIn, prev}. prev is a register that loads HS_DataIn every cycle in all states.
  - Offset k in 0..7 matches when W[k+7:k]==SYNC_WORD; the lowest matching k wins.
  - On a match: latch k, -> RX_HS_DATA.
  - On the cycle that completes SYNC_TIMEOUT cycles without a match: -> RX_ERR. A match in that same cycle wins.
- RX_HS_DATA:
  - Each cycle, RxDataHS <= W[k+7:k] and RxValidHS <= 1.
  - LP-11 -> RX_STOP; RxValidHS and RxActiveHS drop on the next edge. Trailer bytes are not stripped.
- RX_ERR:
  - HSRX_EN=0; wait for LP-11 -> RX_STOP.
- LP-11 in any state other than RX_STOP returns to RX_STOP. All counters clear on every state entry.
- HSRX_EN = 1 exactly in RX_HS_PREP, RX_HS_SYNC and RX_HS_DATA.

## Timing
- All outputs are registered.
- Reset values: DphyRxState=0, RxStopState=1, all other outputs 0, prev=0, k=0.
- Reset is honored in any state, including mid-burst. Outputs take reset values at the next edge.
- LP-00 sampled at cycle t (in RX_HS_RQST) -> HSRX_EN high from t+1. Sync search starts at t+1+SETTLE_CYCLES.
- If SYNC_WORD enters HS_DataIn at cycle t and matches at offset 0, the match occurs at t+1. RxSyncHS pulses and RxActiveHS rises at t+2.
- In general, a payload byte whose final bit arrives at cycle n is valid on RxDataHS at n+2. One byte is delivered per cycle with no gaps.
- RxStopState mirrors state==RX_STOP one cycle later.
- ErrSotSyncHS pulses in the first RX_ERR cycle.

## Configuration
- RX_SOT_1BIT_TOL_EN defined:
  - If no offset matches exactly, the lowest offset whose window byte has Hamming distance 1 from SYNC_WORD is accepted.
  - ErrSotHS pulses in the same cycle as RxSyncHS.
  - An exact match at any offset takes priority over a 1-bit match.
- RX_SOT_1BIT_TOL_EN undefined: exact match only; ErrSotHS tied to 0.

## Test plan
- Basic burst, defaults:
  - Stimulus: LP-11, LP-01, then LP-00 at cycle 10; HS_DataIn=0xB8 at cycle 15, then 0x12, 0x34; LP-11 at cycle 18.
  - Response: HSRX_EN high cycles 11..18; RxSyncHS pulse at 17; RxDataHS 0x12 at 18; burst ends at 19 with no 0x34 delivered.
- Offset 3 alignment:
  - Stimulus: prev=0xC0, HS_DataIn=0x05 during sync search, followed by 0xA0, 0xFF.
  - Response: lock at k=3; subsequent RxDataHS = W[10:3] of each window.
- Timeout:
  - Stimulus: only 0x00 during search.
  - Response: ErrSotSyncHS pulse after 16 cycles; DphyRxState=5; HSRX_EN=0; LP-11 returns to state 0 with RxStopState=1.
- Aborted request:
  - Stimulus: LP-01 then LP-10.
  - Response: back to RX_STOP; HSRX_EN never asserted.
- 1-bit sync error:
  - Stimulus: 0xB9 at offset 0.
  - Response: with RX_SOT_1BIT_TOL_EN, RxSyncHS and ErrSotHS pulse together and data flows; without it, timeout as above.
- Reset mid-burst:
  - Stimulus: RxRst=1 during RX_HS_DATA.
  - Response: next edge RxValidHS=0, RxActiveHS=0, HSRX_EN=0, RxStopState=1, DphyRxState=0.
